// File: rtl/data_mem_responder_if.sv
// Bus between the EX/MEM stage (master) and the data-memory responder (slave).
// Optional misalign flag is carried only when DMEM_MISALIGN_CHK_EN is defined.
interface data_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
`ifdef DMEM_MISALIGN_CHK_EN
  logic        misalign;

  modport master (output mem_read, mem_write, addr, wdata,
                  input  rdata, done, stall, misalign);
  modport slave  (input  mem_read, mem_write, addr, wdata,
                  output rdata, done, stall, misalign);
`else
  modport master (output mem_read, mem_write, addr, wdata,
                  input  rdata, done, stall);
  modport slave  (input  mem_read, mem_write, addr, wdata,
                  output rdata, done, stall);
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory slave for lw/sw. Latches the request in IDLE,
// burns WAIT_CYCLES wait states, performs the access on entry to RESP and
// pulses done there. stall holds the pipeline until the response cycle.
// Optional feature macro: DMEM_MISALIGN_CHK_EN (misaligned requests complete
// immediately with misalign=1 and no memory side effect).
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic          mis;
  } req_t;

  state_t      state;
  logic [3:0]  cnt;
  req_t        req_q;
  req_t        acc;
  logic        req;
  logic        mis_now;
  logic        to_resp;
  logic [31:0] rdata_q;
  logic        done_q;
  logic [31:0] mem [DEPTH];

  // Address bits outside the word index are don't-care by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

  // Current access: live inputs while IDLE (zero-wait path), latched otherwise.
  always_comb begin
    req = bus.mem_read | bus.mem_write;
`ifdef DMEM_MISALIGN_CHK_EN
    mis_now = (bus.addr[1:0] != 2'b00);
`else
    mis_now = 1'b0;
`endif
    acc = req_q;
    if (state == IDLE) begin
      acc.wr    = bus.mem_write;
      acc.idx   = bus.addr[AW+1:2];
      acc.wdata = bus.wdata;
      acc.mis   = mis_now;
    end
    // Reset on the completing edge aborts the access, including its write.
    to_resp = reset_n &
              (((state == IDLE) & req & ((WAIT_CYCLES == 0) | mis_now)) |
               ((state == WAIT) & (cnt == 4'd0)));
  end

  // Memory write on entry to RESP; array is never cleared.
  always_ff @(posedge clk) begin
    if (to_resp & acc.wr & ~acc.mis)
      mem[acc.idx] <= acc.wdata;
  end

  // Request FSM plus registered done/rdata.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      req_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      done_q <= to_resp;
      if (to_resp & ~acc.wr & ~acc.mis)
        rdata_q <= mem[acc.idx];
      case (state)
        IDLE: if (req) begin
          req_q <= acc;
          if ((WAIT_CYCLES == 0) || mis_now) begin
            state <= RESP;
          end else begin
            cnt   <= 4'(WAIT_CYCLES - 1);
            state <= WAIT;
          end
        end
        WAIT: if (cnt == 4'd0) state <= RESP;
              else             cnt   <= cnt - 4'd1;
        // Request still visible here belongs to the access just finished.
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_CHK_EN
  logic mis_q;

  // Misalign flag accompanies the done pulse of a rejected access.
  always_ff @(posedge clk) begin
    if (!reset_n) mis_q <= 1'b0;
    else          mis_q <= to_resp & acc.mis;
  end

  assign bus.misalign = mis_q;
`endif

  assign bus.stall = ((state == IDLE) & req) | (state == WAIT);
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: one instance with 2 wait
// states / 256 words, one with 0 wait states / 16 words. Directed scenarios
// followed by random traffic checked against an address-indexed model.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst2_n = 1'b0;
  logic rst0_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  data_mem_responder_if bus2 ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset_n(rst2_n), .bus(bus2));
  data_mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(rst0_n), .bus(bus0));

  always #5 clk = ~clk;

  // Reference model: word contents keyed by word index, last load value.
  logic [31:0] m2 [int];
  logic [31:0] m0 [int];
  logic [31:0] rdm [2];
  int          wl2 [$];
  int          wl0 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (which == 0) begin
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.wdata = d;
    end else begin
      bus2.mem_read = rd; bus2.mem_write = wr; bus2.addr = a; bus2.wdata = d;
    end
  endtask

  task automatic sample(input int which, output logic st, output logic dn,
                        output logic [31:0] rd, output logic ms);
    ms = 1'b0;
    if (which == 0) begin
      st = bus0.stall; dn = bus0.done; rd = bus0.rdata;
`ifdef DMEM_MISALIGN_CHK_EN
      ms = bus0.misalign;
`endif
    end else begin
      st = bus2.stall; dn = bus2.done; rd = bus2.rdata;
`ifdef DMEM_MISALIGN_CHK_EN
      ms = bus2.misalign;
`endif
    end
  endtask

  // One complete transaction: request held until the done cycle.
  task automatic access(input int which, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
    int          w;
    int          dep;
    int          idx;
    bit          mis;
    int          lat;
    logic [31:0] prev;
    logic        st, dn, ms;
    logic [31:0] rv;
    w    = (which == 0) ? 0 : 2;
    dep  = (which == 0) ? 16 : 256;
    idx  = int'((a >> 2) % 32'(dep));
    mis  = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    mis  = (a[1:0] != 2'b00);
`endif
    prev = rdm[which];
    if (!mis) begin
      if (wr) begin
        if (which == 0) m0[idx] = d; else m2[idx] = d;
      end else if (rd) begin
        rdm[which] = (which == 0) ? m0[idx] : m2[idx];
      end
    end
    lat = mis ? 0 : w;
    @(negedge clk);
    drive(which, rd, wr, a, d);
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      sample(which, st, dn, rv, ms);
      chk($sformatf("stall_wait u%0d c%0d", which, c), {31'd0, st}, 32'd1);
      chk($sformatf("done_early u%0d c%0d", which, c), {31'd0, dn}, 32'd0);
      chk($sformatf("rdata_hold u%0d c%0d", which, c), rv, prev);
    end
    @(negedge clk);
    #1;
    sample(which, st, dn, rv, ms);
    chk($sformatf("done u%0d a=%h", which, a), {31'd0, dn}, 32'd1);
    chk($sformatf("stall_resp u%0d", which), {31'd0, st}, 32'd0);
    chk($sformatf("rdata u%0d a=%h", which, a), rv, rdm[which]);
`ifdef DMEM_MISALIGN_CHK_EN
    chk($sformatf("misalign u%0d a=%h", which, a), {31'd0, ms}, {31'd0, mis});
`endif
  endtask

  task automatic idle(input int which);
    logic st, dn, ms;
    logic [31:0] rv;
    @(negedge clk);
    drive(which, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    sample(which, st, dn, rv, ms);
    chk($sformatf("idle_stall u%0d", which), {31'd0, st}, 32'd0);
    chk($sformatf("idle_done u%0d", which), {31'd0, dn}, 32'd0);
  endtask

  task automatic rand_traffic(input int which, input int n);
    int          dep;
    int          idx;
    bit          rd, wr;
    logic [31:0] a, d, lo;
    dep = (which == 0) ? 16 : 256;
    for (int i = 0; i < n; i++) begin
      wr = ((which == 0 ? wl0.size() : wl2.size()) == 0) || ($urandom_range(0, 1) == 1);
      rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      if (wr) idx = $urandom_range(0, 15);
      else if (which == 0) idx = wl0[$urandom_range(0, wl0.size() - 1)];
      else idx = wl2[$urandom_range(0, wl2.size() - 1)];
`ifdef DMEM_MISALIGN_CHK_EN
      lo = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
`else
      lo = 32'($urandom_range(0, 3));
`endif
      a = 32'((idx + dep * $urandom_range(0, 3)) * 4) | lo;
      d = $urandom;
      access(which, rd, wr, a, d);
`ifdef DMEM_MISALIGN_CHK_EN
      if (wr && lo == 32'd0) begin
`else
      if (wr) begin
`endif
        if (which == 0) wl0.push_back(idx); else wl2.push_back(idx);
      end
      if ($urandom_range(0, 3) == 0) idle(which);
    end
  endtask

  initial begin
    logic st, dn, ms;
    logic [31:0] rv;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    rdm[0] = 32'd0;
    rdm[1] = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      sample(u, st, dn, rv, ms);
      chk($sformatf("rst_stall u%0d", u), {31'd0, st}, 32'd0);
      chk($sformatf("rst_done u%0d", u), {31'd0, dn}, 32'd0);
      chk($sformatf("rst_rdata u%0d", u), rv, 32'd0);
`ifdef DMEM_MISALIGN_CHK_EN
      chk($sformatf("rst_mis u%0d", u), {31'd0, ms}, 32'd0);
`endif
    end
    rst2_n = 1'b1;
    rst0_n = 1'b1;

    // Write then read with two wait states.
    access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0);
    // Simultaneous read+write acts as a write.
    access(1, 1'b1, 1'b1, 32'h8, 32'h12345678);
    access(1, 1'b1, 1'b0, 32'h8, 32'h0);
    // Reset on the completing edge of a write discards it.
    access(1, 1'b0, 1'b1, 32'h20, 32'h11111111);
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 32'h20, 32'h22222222);
    #1; sample(1, st, dn, rv, ms);
    chk("abort_stall_t0", {31'd0, st}, 32'd1);
    @(negedge clk);
    #1; sample(1, st, dn, rv, ms);
    chk("abort_stall_t1", {31'd0, st}, 32'd1);
    @(negedge clk);
    rst2_n = 1'b0;
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    #1; sample(1, st, dn, rv, ms);
    chk("abort_stall", {31'd0, st}, 32'd0);
    chk("abort_done", {31'd0, dn}, 32'd0);
    chk("abort_rdata", rv, 32'd0);
    rst2_n = 1'b1;
    rdm[1] = 32'd0;
    access(1, 1'b1, 1'b0, 32'h20, 32'h0);
    // Address wrap: 0x400 aliases word 0.
    access(1, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
    access(1, 1'b1, 1'b0, 32'h0, 32'h0);
    // Low address bits: misaligned reject or ignored, depending on build.
    access(1, 1'b0, 1'b1, 32'h13, 32'hCAFEF00D);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0);
    idle(1);
    wl2.push_back(0); wl2.push_back(2); wl2.push_back(4); wl2.push_back(8);
    rand_traffic(1, 40);
    idle(1);

    // Zero wait states, back-to-back reads.
    access(0, 1'b0, 1'b1, 32'h0, 32'h0BADF00D);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0);
    access(0, 1'b1, 1'b0, 32'h40, 32'h0);
    wl0.push_back(0);
    rand_traffic(0, 30);
    idle(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end
endmodule
